// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } muldiv_state_t;

    // LO value reported for any divide by zero
    localparam logic [DATA_W-1:0] DIV0_LO = {DATA_W{1'b1}};

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with sign correction applied on the way out.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    muldiv_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             isDiv;
    logic             isSigned;
    logic             signQ;
    logic             signR;
    logic             divZero;
    logic [WIDTH-1:0] rawA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;

    logic             reqSigned;
    logic             reqDiv;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    assign reqSigned = (op == OP_MULT) || (op == OP_DIV);
    assign reqDiv    = (op == OP_DIV)  || (op == OP_DIVU);
    assign busy      = (state != IDLE);

    cond_neg #(.WIDTH(WIDTH)) u_negA (.x(a), .neg(reqSigned & a[WIDTH-1]), .y(absA));
    cond_neg #(.WIDTH(WIDTH)) u_negB (.x(b), .neg(reqSigned & b[WIDTH-1]), .y(absB));

    // Per-iteration datapath: the multiply shifts {accHi, accLo} right, the divide shifts
    // the partial remainder left through a WIDTH+1 bit window so the compare never overflows.
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divDiff;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = (divShift >= {1'b0, opB});
        divDiff  = divShift[WIDTH-1:0] - opB;
    end

    logic [2*WIDTH-1:0] prodRes;
    logic [WIDTH-1:0]   quotRes;
    logic [WIDTH-1:0]   remRes;

    cond_neg #(.WIDTH(2*WIDTH)) u_negProd (.x({accHi, accLo}), .neg(isSigned & signQ), .y(prodRes));
    cond_neg #(.WIDTH(WIDTH))   u_negQuot (.x(accLo), .neg(isSigned & signQ), .y(quotRes));
    cond_neg #(.WIDTH(WIDTH))   u_negRem  (.x(accHi), .neg(isSigned & signR), .y(remRes));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            isDiv    <= 1'b0;
            isSigned <= 1'b0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            divZero  <= 1'b0;
            rawA     <= '0;
            opB      <= '0;
            accHi    <= '0;
            accLo    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A new request wins over MTHI/MTLO issued in the same cycle
                    if (start) begin
                        isDiv    <= reqDiv;
                        isSigned <= reqSigned;
                        signQ    <= a[WIDTH-1] ^ b[WIDTH-1];
                        signR    <= a[WIDTH-1];
                        divZero  <= reqDiv && (b == '0);
                        rawA     <= a;
                        opB      <= absB;
                        accHi    <= '0;
                        accLo    <= absA;
                        cnt      <= '0;
                        state    <= RUN;
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                RUN: begin
                    if (isDiv) begin
                        accHi <= divFits ? divDiff : divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], divFits};
                    end else begin
                        accHi <= mulSum[WIDTH:1];
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) state <= FINISH;
                end
                FINISH: begin
                    if (isDiv && divZero) begin
                        hi <= rawA;
                        lo <= DIV0_LO;
                    end else if (isDiv) begin
                        hi <= remRes;
                        lo <= quotRes;
                    end else begin
                        hi <= prodRes[2*WIDTH-1:WIDTH];
                        lo <= prodRes[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports each miss with $error
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents a request for one edge; returns at the negedge just after acceptance
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] expHi, input logic [31:0] expLo);
        int cyc;
        applyStimulus(o, x, y);
        waitDone(cyc);
        checkOutput({tag, "_busycycles"}, 64'(cyc), 64'd33);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int doneSeen;

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("mult_neg7x6", OP_MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        runOp("div_neg7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        runOp("div_by0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        runOp("div_minint", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runOp("mult_minint_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        runOp("divu_plain", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // MTHI and MTLO together in IDLE, one edge of latency
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wd    = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("mthi", 64'(hi), 64'h1234);
        checkOutput("mtlo", 64'(lo), 64'h1234);
        @(negedge clk);
        lo_we = 1'b1;
        wd    = 32'h0000_5678;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo_only_lo", 64'(lo), 64'h5678);
        checkOutput("mtlo_only_hi", 64'(hi), 64'h1234);

        // MTLO and a second start while busy must be ignored
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd3;
        b     = 32'd3;
        lo_we = 1'b1;
        wd    = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        checkOutput("busy_hold_lo", 64'(lo), 64'h5678);
        checkOutput("busy_hold_hi", 64'(hi), 64'h1234);
        waitDone(cyc);
        checkOutput("busy_ign_timeout", 64'(cyc < 100), 64'd1);
        checkOutput("busy_ign_done", 64'(done), 64'd1);
        checkOutput("busy_ign_hi", 64'(hi), 64'd2);
        checkOutput("busy_ign_lo", 64'(lo), 64'd14);
        @(negedge clk);
        checkOutput("busy_ign_nosecond", 64'(busy), 64'd0);

        // start and hi_we in the same IDLE cycle: the write is dropped
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd3;
        b     = 32'd4;
        hi_we = 1'b1;
        wd    = 32'h0000_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        checkOutput("start_prio_busy", 64'(busy), 64'd1);
        waitDone(cyc);
        checkOutput("start_prio_cycles", 64'(cyc), 64'd33);
        checkOutput("start_prio_hi", 64'(hi), 64'd0);
        checkOutput("start_prio_lo", 64'(lo), 64'd12);

        // Reset around iteration 10 of a DIVU aborts it without a done pulse
        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("midrst_nodone", 64'(doneSeen), 64'd0);
        checkOutput("midrst_idle", 64'(busy), 64'd0);

        runOp("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
